// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: MUL/DIV sequencer states
// and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        MD_DONE = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// MUL/DIV sequencer: issues the start pulse, holds the front of the pipe while
// the unit works, and forces a release with a sticky error when it never answers.
module md_seq
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic md_op,
    input  logic md_done,
    input  logic mem_stall,
    input  logic issue_blk,
    output logic md_start,
    output logic md_hold,
    output logic md_err
);

    localparam int TMO_W = $clog2(MD_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);

    hz_state_t        state_r;
    hz_state_t        state_nxt_s;
    logic [TMO_W-1:0] cnt_r;
    logic             err_r;
    logic             timeout_s;
    logic             done_eff_s;

    // A timeout counts as a completion so the pipe is never wedged forever
    assign timeout_s  = (state_r == MD_WAIT) && (cnt_r == TMO_LAST) && !md_done;
    assign done_eff_s = md_done || timeout_s;

    // Next-state decode; the MD_WAIT release cycle deliberately drops the hold
    always_comb begin
        state_nxt_s = state_r;
        md_start    = 1'b0;
        md_hold     = 1'b0;
        case (state_r)
            RUN: begin
                if (md_op && !issue_blk) begin
                    md_start    = 1'b1;
                    state_nxt_s = MD_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MD_WAIT: begin
                if (done_eff_s && !mem_stall) begin
                    state_nxt_s = RUN;
                end else if (done_eff_s) begin
                    state_nxt_s = MD_DONE;
                end else begin
                    md_hold     = 1'b1;
                    state_nxt_s = MD_WAIT;
                end
            end
            MD_DONE: begin
                if (!mem_stall) begin
                    state_nxt_s = RUN;
                end else begin
                    md_hold     = 1'b1;
                    state_nxt_s = MD_DONE;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= TMO_ZERO;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (md_start) begin
                cnt_r <= TMO_ZERO;
            end else if (state_r == MD_WAIT) begin
                cnt_r <= cnt_r + TMO_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (timeout_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign md_err = err_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: prioritises memory wait, MUL/DIV hold,
// taken-branch flush and load-use stall into per-stage enables and flushes.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_IF_ID,
    input  logic [4:0]       rs2_IF_ID,
    input  logic [4:0]       rd_ID_EX,
    input  logic             Mem_Read_ID_EX,
    input  logic             md_op_ID_EX,
    input  logic             md_done,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Bubble,
    output logic             MEM_WB_Bubble,
    output logic             md_start,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic             mem_stall_s;
    logic             load_use_s;
    logic             issue_blk_s;
    logic             md_start_s;
    logic             md_hold_s;
    logic [CNT_W-1:0] stall_cnt_r;

    assign mem_stall_s = dmem_req_MEM && !dmem_ready;
    assign load_use_s  = Mem_Read_ID_EX && (rd_ID_EX != REG_X0) &&
                         ((rd_ID_EX == rs1_IF_ID) || (rd_ID_EX == rs2_IF_ID));
    // An issue waits while the pipe is frozen or the EX slot is being squashed
    assign issue_blk_s = mem_stall_s || branch_taken_EX;

    md_seq #(
        .MD_TIMEOUT (MD_TIMEOUT)
    ) u_md_seq (
        .clk       (clk),
        .rst       (rst),
        .md_op     (md_op_ID_EX),
        .md_done   (md_done),
        .mem_stall (mem_stall_s),
        .issue_blk (issue_blk_s),
        .md_start  (md_start_s),
        .md_hold   (md_hold_s),
        .md_err    (md_err)
    );

    // Priority mux: reset, memory wait, md hold, branch, md issue, load-use
    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        EX_MEM_Write  = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Bubble = 1'b0;
        MEM_WB_Bubble = 1'b0;
        md_start      = 1'b0;
        if (rst) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
            EX_MEM_Bubble = 1'b1;
            MEM_WB_Bubble = 1'b1;
        end else if (mem_stall_s) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
        end else if (md_hold_s) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (branch_taken_EX) begin
            IF_ID_Flush   = 1'b1;
            ID_EX_Flush   = 1'b1;
        end else if (md_start_s) begin
            md_start      = 1'b1;
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
        end else if (load_use_s) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Flush   = 1'b1;
        end else begin
            PC_Write      = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= CNT_ZERO;
        end else if (!PC_Write && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule
